// File: rtl/apb_master_bridge.sv
// Request/response to APB master bridge: one transfer at a time through IDLE/SETUP/ACCESS/RESP,
// with an optional ACCESS-phase wait timeout that returns an error response.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    output logic [31:0] m_paddr,
    output logic        m_penable,
    output logic        m_psel,
    input  logic        m_pready,
    input  logic [31:0] m_prdata
);

    localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [31:0] ERR_PAT = 32'hdeadbeef;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // The abort condition only matters while m_pready is low; a ready response always wins.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(LAST));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // APB strobes are decoded from the state so reset drops them without waiting for an edge.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        m_psel     = 1'b0;
        m_penable  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SETUP;
            end
            SETUP: begin
                m_psel    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
                if (m_pready || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter is held at zero outside ACCESS, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!m_pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pwrite   <= 1'b0;
            m_paddr    <= '0;
            m_pwdata   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                m_pwrite <= req_wr;
                m_paddr  <= req_addr;
                m_pwdata <= req_wdata;
            end
            if (state == ACCESS) begin
                if (m_pready) begin
                    resp_rdata <= m_pwrite ? 32'h0 : m_prdata;
                    resp_err   <= 1'b0;
                end else if (timeout_hit) begin
                    resp_rdata <= ERR_PAT;
                    resp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: one default instance plus one built with TIMEOUT=4.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, t_req_valid;
    logic        req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        resp_ready;
    logic        m_pready;
    logic [31:0] m_prdata;

    logic        req_ready, resp_valid, resp_err, m_pwrite, m_penable, m_psel;
    logic [31:0] resp_rdata, m_pwdata, m_paddr;
    logic        t_req_ready, t_resp_valid, t_resp_err, t_m_pwrite, t_m_penable, t_m_psel;
    logic [31:0] t_resp_rdata, t_m_pwdata, t_m_paddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_master_bridge dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_paddr(m_paddr),
        .m_penable(m_penable), .m_psel(m_psel), .m_pready(m_pready), .m_prdata(m_prdata)
    );

    apb_master_bridge #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rstn(rstn), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(t_resp_valid), .resp_ready(resp_ready), .resp_rdata(t_resp_rdata),
        .resp_err(t_resp_err), .m_pwrite(t_m_pwrite), .m_pwdata(t_m_pwdata), .m_paddr(t_m_paddr),
        .m_penable(t_m_penable), .m_psel(t_m_psel), .m_pready(m_pready), .m_prdata(m_prdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; req_valid = 1'b0; t_req_valid = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; m_pready = 1'b0; m_prdata = '0;
        #3;
        n_vec++; if (m_psel !== 1'b0 || m_penable !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got psel=%b penable=%b want 0 0", m_psel, m_penable); end
        n_vec++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || m_pwrite !== 1'b0) begin n_err++; $display("FAIL reset_flags: got rv=%b err=%b pwrite=%b want 0 0 0", resp_valid, resp_err, m_pwrite); end
        n_vec++; if (m_paddr !== 32'h0 || m_pwdata !== 32'h0 || resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", m_paddr, m_pwdata, resp_rdata); end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0002_0010; req_wdata = 32'h5555_AAAA;
        m_pready = 1'b1; m_prdata = 32'h1234_5678;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
        n_vec++; if (m_psel !== 1'b1 || m_penable !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL read_setup: got psel=%b penable=%b rv=%b want 1 0 0", m_psel, m_penable, resp_valid); end
        n_vec++; if (m_paddr !== 32'h0002_0010 || m_pwrite !== 1'b0) begin n_err++; $display("FAIL read_setup_addr: got %h/%b want 00020010/0", m_paddr, m_pwrite); end
        tick();
        n_vec++; if (m_psel !== 1'b1 || m_penable !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL read_access: got psel=%b penable=%b rv=%b want 1 1 0", m_psel, m_penable, resp_valid); end
        n_vec++; if (m_paddr !== 32'h0002_0010) begin n_err++; $display("FAIL read_access_addr: got %h want 00020010", m_paddr); end
        tick();
        m_pready = 1'b0; m_prdata = 32'h0BAD_0BAD;
        n_vec++; if (resp_valid !== 1'b1 || m_psel !== 1'b0 || m_penable !== 1'b0) begin n_err++; $display("FAIL read_resp_timing: got rv=%b psel=%b penable=%b want 1 0 0", resp_valid, m_psel, m_penable); end
        n_vec++; if (resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0) begin n_err++; $display("FAIL read_resp_data: got %h err=%b want 12345678 0", resp_rdata, resp_err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL read_done: got rv=%b rdy=%b want 0 1", resp_valid, req_ready); end
        n_vec++; if (m_paddr !== 32'h0002_0010) begin n_err++; $display("FAIL read_addr_hold: got %h want 00020010", m_paddr); end
    endtask

    task automatic test_write_wait;
        int en_cycles;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0001_0004; req_wdata = 32'hCAFE_F00D;
        m_pready = 1'b0;
        tick();
        req_valid = 1'b0; req_wdata = 32'h0;
        tick();
        en_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_penable === 1'b1) en_cycles++;
            n_vec++; if (m_pwdata !== 32'hCAFE_F00D || m_pwrite !== 1'b1 || m_paddr !== 32'h0001_0004) begin n_err++; $display("FAIL write_hold[%0d]: got %h/%b/%h want cafef00d/1/00010004", i, m_pwdata, m_pwrite, m_paddr); end
            if (i == 5) m_pready = 1'b1;
            tick();
        end
        m_pready = 1'b0;
        n_vec++; if (en_cycles != 6 || m_penable !== 1'b0) begin n_err++; $display("FAIL write_enable_len: got %0d (now %b) want 6 (now 0)", en_cycles, m_penable); end
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_err++; $display("FAIL write_resp: got rv=%b %h err=%b want 1 00000000 0", resp_valid, resp_rdata, resp_err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int en_cycles;
        t_req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_0400;
        m_pready = 1'b0;
        tick();
        t_req_valid = 1'b0;
        tick();
        en_cycles = 0;
        while (t_m_penable === 1'b1 && en_cycles < 20) begin
            en_cycles++;
            tick();
        end
        n_vec++; if (en_cycles != 4) begin n_err++; $display("FAIL timeout_len: got %0d want 4", en_cycles); end
        n_vec++; if (t_resp_valid !== 1'b1 || t_resp_err !== 1'b1 || t_resp_rdata !== 32'hdeadbeef) begin n_err++; $display("FAIL timeout_resp: got rv=%b err=%b %h want 1 1 deadbeef", t_resp_valid, t_resp_err, t_resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++; if (t_req_ready !== 1'b1 || t_resp_valid !== 1'b0) begin n_err++; $display("FAIL timeout_done: got rdy=%b rv=%b want 1 0", t_req_ready, t_resp_valid); end
    endtask

    task automatic test_timeout_race;
        t_req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_0500;
        m_pready = 1'b0;
        tick();
        t_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (t_m_penable !== 1'b1) begin n_err++; $display("FAIL race_enable[%0d]: got %b want 1", i, t_m_penable); end
            if (i == 3) begin m_pready = 1'b1; m_prdata = 32'hA5A5_0001; end
            tick();
        end
        m_pready = 1'b0;
        n_vec++; if (t_resp_valid !== 1'b1 || t_resp_err !== 1'b0 || t_resp_rdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL race_resp: got rv=%b err=%b %h want 1 0 a5a50001", t_resp_valid, t_resp_err, t_resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_0100;
        m_pready = 1'b1; m_prdata = 32'h1111_2222;
        tick();
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_setup_ready: got %b want 0", req_ready); end
        tick();
        tick();
        m_prdata = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1111_2222 || req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall[%0d]: got rv=%b %h rdy=%b want 1 11112222 0", i, resp_valid, resp_rdata, req_ready); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_addr = 32'h0000_0200;
        n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || m_psel !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got rdy=%b rv=%b psel=%b want 1 0 0", req_ready, resp_valid, m_psel); end
        tick();
        req_valid = 1'b0;
        n_vec++; if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_paddr !== 32'h0000_0200) begin n_err++; $display("FAIL b2b_next_accept: got psel=%b penable=%b addr=%h want 1 0 00000200", m_psel, m_penable, m_paddr); end
        tick();
        tick();
        m_pready = 1'b0;
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h9999_9999) begin n_err++; $display("FAIL b2b_second_resp: got rv=%b %h want 1 99999999", resp_valid, resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int rv_seen;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'h0000_7777;
        m_pready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        n_vec++; if (m_penable !== 1'b1) begin n_err++; $display("FAIL mid_access: got %b want 1", m_penable); end
        #2 rstn = 1'b0;
        #1;
        n_vec++; if (m_psel !== 1'b0 || m_penable !== 1'b0 || m_paddr !== 32'h0) begin n_err++; $display("FAIL mid_async_drop: got psel=%b penable=%b addr=%h want 0 0 0", m_psel, m_penable, m_paddr); end
        m_pready = 1'b1;
        tick();
        #3 rstn = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready: got %b want 1", req_ready); end
        m_pready = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid !== 1'b0) rv_seen++;
        end
        n_vec++; if (rv_seen != 0 || req_ready !== 1'b1) begin n_err++; $display("FAIL mid_no_resp: got rv_cycles=%0d rdy=%b want 0 1", rv_seen, req_ready); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
